// File: rtl/instr_packer.sv
// instr_packer: packs decoded RV32 fields into instruction words and streams them to instruction memory.
// Optional immediate range checking is enabled by defining INSTR_PACKER_RANGE_CHECK_EN.
`default_nettype none

module instr_packer #(
  parameter int              W         = 32,
  parameter int              AW        = 32,
  parameter logic [AW-1:0]   BASE_ADDR = '0,
  parameter int              DEPTH     = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   IMMsrc,
  input  logic [6:0]                   opcode,
  input  logic [2:0]                   funct3,
  input  logic [6:0]                   funct7,
  input  logic [4:0]                   rd,
  input  logic [4:0]                   rs1,
  input  logic [4:0]                   rs2,
  input  logic [W-1:0]                 imm,
  output logic                         wr_en,
  input  logic                         wr_ready,
  output logic [AW-1:0]                wr_addr,
  output logic [W-1:0]                 wr_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         err
);

  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [1:0] FMT_I = 2'b00;
  localparam logic [1:0] FMT_S = 2'b01;
  localparam logic [1:0] FMT_B = 2'b10;
  localparam logic [1:0] FMT_U = 2'b11;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] slot;
  logic [W-1:0]  word_nxt;
  logic [AW-1:0] addr_nxt;
  logic          accept;
  logic          retire;
  logic          range_bad;
  logic          write_accept;
  logic          last_retire;

  // No supported format carries funct7; the port exists for interface symmetry with the decoder.
  logic unused_funct7;
  assign unused_funct7 = ^funct7;

  always_comb begin
    word_nxt = '0;
    case (IMMsrc)
      FMT_I: word_nxt = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: word_nxt = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: word_nxt = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: word_nxt = {imm[31:12], rd, opcode};
      default: word_nxt = '0;
    endcase
  end

`ifdef INSTR_PACKER_RANGE_CHECK_EN
  // An immediate fits when every bit above the field's top bit copies that top bit.
  always_comb begin
    range_bad = 1'b0;
    case (IMMsrc)
      FMT_I, FMT_S: range_bad = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        range_bad = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
      FMT_U:        range_bad = |imm[11:0];
      default:      range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  assign addr_nxt     = BASE_ADDR + (AW'(slot) << 2);
  assign accept       = in_valid && in_ready;
  assign retire       = wr_en && wr_ready;
  assign write_accept = accept && !range_bad;
  assign last_retire  = retire && (count == CW'(DEPTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (accept && range_bad) begin
            state_nxt = S_HALT;
          end else if (last_retire) begin
            state_nxt = S_FULL;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Output logic
  always_comb begin
    in_ready = (state == S_RUN) && (slot < CW'(DEPTH)) && !start && (!wr_en || wr_ready);
    full     = (state == S_FULL);
`ifdef INSTR_PACKER_RANGE_CHECK_EN
    err      = (state == S_HALT);
`else
    err      = 1'b0;
`endif
  end

  // Write port and counters; a pending write still drains after a range error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      slot    <= '0;
      count   <= '0;
    end else if (start) begin
      wr_en   <= 1'b0;
      slot    <= '0;
      count   <= '0;
    end else begin
      if (write_accept) begin
        wr_en   <= 1'b1;
        wr_data <= word_nxt;
        wr_addr <= addr_nxt;
        slot    <= slot + 1'b1;
      end else if (retire) begin
        wr_en   <= 1'b0;
      end
      if (retire) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/instr_packer.md
# instr_packer

Instruction encoder and program-memory writer; the inverse of the core's immediate extender. Accepts decoded fields (opcode, registers, funct bits, full-width immediate, `IMMsrc` format select) over a valid/ready handshake. Packs them into 32-bit RV32 instruction words and streams the words into instruction memory at consecutive word addresses. Sits between the test/boot loader and the instruction-memory write port.

## Interface
- `W`, 32: instruction/immediate width; only 32 supported.
- `AW`, 32: write address width.
- `BASE_ADDR`, 0: byte address of first written word.
- `DEPTH`, 256: max words per program; ≥1.

- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: pulse; (re)starts a program at `BASE_ADDR`.
- `in_valid` in 1: field bundle valid.
- `in_ready` out 1: bundle accepted on `in_valid && in_ready`.
- `IMMsrc` in 2: format select.
  - 00 I, 01 S, 10 B, 11 U.
  - Same encoding as the extender.
- `opcode` in 7, `funct3` in 3, `funct7` in 7, `rd` in 5, `rs1` in 5, `rs2` in 5: instruction fields.
- `imm` in W: sign-extended immediate as the extender would output it.
- `wr_en` out 1: write request to instruction memory.
- `wr_ready` in 1: memory accepts write on `wr_en && wr_ready`.
- `wr_addr` out AW: byte address of `wr_data`.
- `wr_data` out W: packed instruction.
- `count` out $clog2(DEPTH+1): words retired since last `start`.
- `full` out 1: DEPTH words retired.
- `err` out 1: sticky immediate range error.

## Operation
- States: IDLE, RUN, FULL, HALT.
  - Reset → IDLE.
  - `start` from any state → RUN.
    - Clears `count`, `full`, `err`, slot index.
    - Flushes any pending write: `wr_en` low next cycle.
- Packing, with opcode always in [6:0]:
  - I: `imm[11:0]`→[31:20], `rs1`→[19:15], `funct3`→[14:12], `rd`→[11:7]. `funct7` ignored.
  - S: `imm[11:5]`→[31:25], `rs2`→[24:20], `rs1`, `funct3`, `imm[4:0]`→[11:7].
  - B: `imm[12]`→31, `imm[10:5]`→[30:25], `rs2`, `rs1`, `funct3`, `imm[4:1]`→[11:8], `imm[11]`→7.
  - U: `imm[31:12]`→[31:12], `rd`→[11:7].
- `in_ready` = state==RUN && slot<DEPTH && !start && (!wr_en || wr_ready).
- On accept:
  - Output register loads packed word.
  - `wr_addr` = `BASE_ADDR` + 4·slot.
  - slot increments.
- On `wr_en && wr_ready`:
  - `count` increments.
  - `wr_en` drops unless a new accept occurs in the same cycle.
- RUN → FULL when the DEPTH-th word retires; `full`=1.
- FULL/HALT: `in_ready`=0 until `start`.
- Address arithmetic is modulo 2^AW. No wrap check; DEPTH bounds it.

## Timing
- Reset values:
  - `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `count`=0, `full`=0, `err`=0.
  - State IDLE.
- Latency: accept at edge N → `wr_en`=1 with data/address valid after edge N (one cycle).
- `wr_data`/`wr_addr` held stable while `wr_en && !wr_ready`.
- Back-to-back throughput: one word/cycle when `wr_ready` stays high. Retire and accept happen in the same edge.
- `start` has priority over a simultaneous `in_valid`: that bundle is not accepted.
- `rst` mid-write: `wr_en` drops immediately (asynchronous). The pending word is lost.

## Configuration
- `INSTR_PACKER_RANGE_CHECK_EN` defined: immediates are checked on accept. Failing checks:
  - I/S: `imm` ≠ sext(`imm[11:0]`).
  - B: `imm[0]`≠0, or `imm` ≠ sext(`imm[12:0]`).
  - U: `imm[11:0]`≠0.
- On a failed check:
  - The bundle is consumed but not written.
  - `err`=1 next cycle; state → HALT.
  - A pending write still completes.
- Not defined: no check; out-of-range bits silently truncated. `err` tied 0; HALT unreachable.

## Test plan
- I-type `addi x1,x0,-1`: `IMMsrc`=00, opcode=0x13, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF, `BASE_ADDR`=0 → next cycle `wr_en`=1, `wr_data`=0xFFF00093, `wr_addr`=0; `count`=1 after retire.
- S then B back-to-back, `wr_ready`=1:
  - `sw x2,8(x1)` (opcode 0x23, funct3=2, rs1=1, rs2=2, imm=8) → 0x0020A423 at address 0.
  - `beq x0,x0,-4` (opcode 0x63, imm=0xFFFFFFFC) → 0xFE000EE3 at address 4, on consecutive cycles.
- Backpressure: `wr_ready`=0 for 3 cycles with second bundle waiting → `wr_data`/`wr_addr` unchanged, `in_ready`=0; second word appears the cycle after `wr_ready` rises.
- Full: `DEPTH`=4, five bundles → addresses 0, 4, 8, 12; fifth never accepted; `full`=1 and `count`=4 after fourth retire; `start` clears both.
- Range (macro defined): I-type imm=0x800 → no write, `err`=1, `in_ready`=0; `start` → `err`=0, RUN.
  - Macro undefined: same stimulus writes `wr_data` with [31:20]=0x800, `err`=0.
- Async reset asserted while `wr_en`=1 and `wr_ready`=0 → all outputs 0 immediately; after release, bundles ignored until `start`.
